// File: rtl/move_writeback_pipe.sv
// move_writeback_pipe: MEM/WB pipeline for move results.
//   Captures each move result (coordinate value plus rt/rd destination) into a
//   MEM register and then a WB register, drives the register-file write port
//   from WB, and forwards MEM/WB data to the x (rt) and y (rd) operands of the
//   instruction currently in ID.
// Ports:
//   Clk, Reset            clock (rising edge), asynchronous active-low reset
//   ex_move/ex_value/ex_sel/ex_rt/ex_rd   move result arriving from EX
//   stall, flush          pipeline hold / kill controls
//   id_rt, id_rd          source indices of the ID instruction
//   wb_en/wb_addr/wb_data register-file write port (registered)
//   fwd_x_*, fwd_y_*      forwarding for x (rt) and y (rd) operands
//   retired_cnt           number of committed move writes (wraps)
module move_writeback_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              ex_move,
  input  logic [DATA_W-1:0] ex_value,
  input  logic              ex_sel,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              stall,
  input  logic              flush,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              fwd_x_en,
  output logic [DATA_W-1:0] fwd_x_data,
  output logic              fwd_y_en,
  output logic [DATA_W-1:0] fwd_y_data,
  output logic [31:0]       retired_cnt
);

  localparam int unsigned CNT_W = 32;

  logic              m_valid_q, m_valid_d;
  logic [REG_AW-1:0] m_addr_q,  m_addr_d;
  logic [DATA_W-1:0] m_data_q,  m_data_d;
  logic              w_valid_q, w_valid_d;
  logic [REG_AW-1:0] w_addr_q,  w_addr_d;
  logic [DATA_W-1:0] w_data_q,  w_data_d;
  logic [CNT_W-1:0]  retired_cnt_q, retired_cnt_d;

  logic [REG_AW-1:0] dst_c;
  logic              cap_valid_c;

  // Destination select and capture qualification; $0 writes are dropped here
  always_comb begin
    dst_c       = ex_sel ? ex_rd : ex_rt;
    cap_valid_c = ex_move & ~flush & (dst_c != '0);
  end

  // Next-state for MEM, WB and the retire counter
  always_comb begin
    m_valid_d     = m_valid_q;
    m_addr_d      = m_addr_q;
    m_data_d      = m_data_q;
    w_valid_d     = m_valid_q;
    w_addr_d      = m_addr_q;
    w_data_d      = m_data_q;
    retired_cnt_d = retired_cnt_q;

    // flush beats stall: MEM becomes a bubble even while stalled
    if (flush) begin
      m_valid_d = 1'b0;
      m_addr_d  = '0;
      m_data_d  = '0;
    end else if (!stall) begin
      m_valid_d = cap_valid_c;
      m_addr_d  = cap_valid_c ? dst_c : '0;
      m_data_d  = cap_valid_c ? ex_value : '0;
    end

    // While MEM is held, WB takes bubbles so the held entry is written once
    if (stall && !flush) begin
      w_valid_d = 1'b0;
      w_addr_d  = '0;
      w_data_d  = '0;
    end

    if (w_valid_q) begin
      retired_cnt_d = retired_cnt_q + CNT_W'(1);
    end
  end

  // Pipeline state registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_valid_q     <= 1'b0;
      m_addr_q      <= '0;
      m_data_q      <= '0;
      w_valid_q     <= 1'b0;
      w_addr_q      <= '0;
      w_data_q      <= '0;
      retired_cnt_q <= '0;
    end else begin
      m_valid_q     <= m_valid_d;
      m_addr_q      <= m_addr_d;
      m_data_q      <= m_data_d;
      w_valid_q     <= w_valid_d;
      w_addr_q      <= w_addr_d;
      w_data_q      <= w_data_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

  // Forwarding from MEM/WB; MEM is younger so it wins, index 0 never forwards
  always_comb begin
    fwd_x_en   = 1'b0;
    fwd_x_data = '0;
    fwd_y_en   = 1'b0;
    fwd_y_data = '0;

    if (id_rt != '0) begin
      if (m_valid_q && (m_addr_q == id_rt)) begin
        fwd_x_en   = 1'b1;
        fwd_x_data = m_data_q;
      end else if (w_valid_q && (w_addr_q == id_rt)) begin
        fwd_x_en   = 1'b1;
        fwd_x_data = w_data_q;
      end
    end

    if (id_rd != '0) begin
      if (m_valid_q && (m_addr_q == id_rd)) begin
        fwd_y_en   = 1'b1;
        fwd_y_data = m_data_q;
      end else if (w_valid_q && (w_addr_q == id_rd)) begin
        fwd_y_en   = 1'b1;
        fwd_y_data = w_data_q;
      end
    end
  end

  assign wb_en       = w_valid_q;
  assign wb_addr     = w_addr_q;
  assign wb_data     = w_data_q;
  assign retired_cnt = retired_cnt_q;

endmodule

// File: doc/move_writeback_pipe.md
Name: move_writeback_pipe

Overview:
- Downstream neighbour of the move-check stage.
- Captures each move result (new coordinate value plus rt/rd select) through two pipeline registers, MEM then WB.
- Drives the register-file write port.
- Supplies forwarding data for the x (rt) and y (rd) operands of the instruction in ID, so back-to-back moves see updated coordinates without stalling.

Parameters:
- DATA_W, 32, width of coordinate values and write data
- REG_AW, 5, register index width

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- ex_move  in  1  move instruction valid in EX
- ex_value  in  DATA_W  new coordinate from move-check
- ex_sel  in  1  destination select: 0 = rt, 1 = rd
- ex_rt  in  REG_AW  rt index of EX instruction
- ex_rd  in  REG_AW  rd index of EX instruction
- stall  in  1  hold MEM stage contents
- flush  in  1  kill EX instruction before capture
- id_rt  in  REG_AW  rt source index of instruction in ID
- id_rd  in  REG_AW  rd source index of instruction in ID
- wb_en  out  1  register-file write enable
- wb_addr  out  REG_AW  register-file write index
- wb_data  out  DATA_W  register-file write data
- fwd_x_en  out  1  forward x (rt) operand
- fwd_x_data  out  DATA_W  forwarded x value
- fwd_y_en  out  1  forward y (rd) operand
- fwd_y_data  out  DATA_W  forwarded y value
- retired_cnt  out  32  count of committed move writes

Behaviour:
- Reset low, asynchronous: m_valid, w_valid, all addr/data registers and retired_cnt go to 0 immediately. In-flight moves are discarded and never written.
- Destination index at capture: dst = ex_sel ? ex_rd : ex_rt. ex_value is ignored when ex_move = 0.
- Captured valid = ex_move & ~flush & (dst != 0). Writes to $0 are dropped and never forwarded.
- MEM stage (m_valid, m_addr, m_data) update per rising edge, in priority order:
  - flush = 1: MEM <= bubble (flush beats stall).
  - else stall = 1: MEM holds.
  - else: MEM <= captured EX entry.
- WB stage (w_valid, w_addr, w_data) update per rising edge:
  - stall = 1 and flush = 0: WB <= bubble. A held MEM entry is written exactly once, after the stall releases.
  - otherwise: WB <= MEM.
- Write port is registered: wb_en = w_valid, wb_addr = w_addr, wb_data = w_data.
- Latency: a move sampled at edge k drives wb_en high during the cycle after edge k+1 (two-edge latency, no stall).
- Forwarding is combinational from MEM/WB registers.
  - fwd_x_en = 1 when (m_valid & m_addr == id_rt) or (w_valid & w_addr == id_rt).
  - MEM match takes priority over WB for fwd_x_data. fwd_y follows the same rules with id_rd.
  - id index 0 never forwards.
  - fwd_*_data = 0 when the matching en = 0.
  - With MEM and WB both targeting the same register, MEM data wins.
- retired_cnt increments by 1 on each rising edge where w_valid = 1; wraps 0xFFFFFFFF -> 0.
- Reset released mid-stream: the first capture occurs at the first rising edge with Reset high.

Test Plan:
- Single move: ex_move=1, ex_sel=0, ex_rt=8, ex_value=5 at edge 1 -> wb_en=1, wb_addr=8, wb_data=5 after edge 2; retired_cnt=1 after edge 3.
- Back-to-back forwarding: move A (rd=9, sel=1, value=3), then with A in MEM set id_rd=9 -> fwd_y_en=1, fwd_y_data=3. Next cycle, with A in WB and a new move B (rd=9, value=4) in MEM -> fwd_y_data=4 (MEM priority).
- Stall: capture move (rt=10, value=7), hold stall=1 for 3 cycles -> wb_en stays 0. After release, exactly one write of 7 to $10; retired_cnt increments by 1 only.
- Flush vs stall: ex_move=1 with flush=1 and stall=1 on the same edge -> MEM bubble, no write, no forward. A prior MEM entry still advances to WB.
- $0 destination: ex_move=1, ex_sel=0, ex_rt=0, value=9 -> wb_en never asserts; id_rt=0 gives fwd_x_en=0.
- Reset mid-operation: moves in both MEM and WB, drive Reset low between edges -> wb_en, fwd_*_en and retired_cnt drop to 0 immediately. No write after Reset returns high.
